// File: rtl/byp_hzd_unit.sv
// byp_hzd_unit: ID-stage forwarding select and load-use hazard detection
module byp_hzd_unit #(
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush_ID,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              re0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              we_rf,
    input  logic              mem_rd,
    output logic              byp0_EX,
    output logic              byp0_DM,
    output logic              byp1_EX,
    output logic              byp1_DM,
    output logic              hzd_stall
);
    logic              we_ie, ld_ie, we_ed, ld_ed, we_dw, ld_dw;
    logic [ADDR_W-1:0] dst_ie, dst_ed, dst_dw;
    logic              m0_ie, m1_ie, m0_ed, m1_ed, bubble;

    function automatic logic match(input logic re, input logic [ADDR_W-1:0] a,
                                   input logic we, input logic [ADDR_W-1:0] d);
        return re && we && (a == d) && !(ZERO_REG && a == '0);
    endfunction

    // Compare ID read ports against the two older in-flight writers; a load in ID_EX forces a stall
    always_comb begin
        m0_ie     = match(re0, p0_addr, we_ie, dst_ie);
        m1_ie     = match(re1, p1_addr, we_ie, dst_ie);
        m0_ed     = match(re0, p0_addr, we_ed, dst_ed);
        m1_ed     = match(re1, p1_addr, we_ed, dst_ed);
        hzd_stall = !flush_ID && ld_ie && (m0_ie || m1_ie);
        bubble    = flush_ID || hzd_stall;
    end

    // Advance the destination shadows and register bypass selects for the instruction entering EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {we_ie, ld_ie, we_ed, ld_ed, we_dw, ld_dw} <= '0;
            {dst_ie, dst_ed, dst_dw}                   <= '0;
            {byp0_EX, byp0_DM, byp1_EX, byp1_DM}       <= '0;
        end else if (!stall) begin
            we_dw   <= we_ed;
            ld_dw   <= ld_ed;
            dst_dw  <= dst_ed;
            we_ed   <= we_ie;
            ld_ed   <= ld_ie;
            dst_ed  <= dst_ie;
            we_ie   <= we_rf && !bubble;
            ld_ie   <= mem_rd && !bubble;
            dst_ie  <= dst_addr;
            byp0_EX <= !bubble && m0_ie && !ld_ie;
            byp0_DM <= !bubble && m0_ed && !m0_ie;
            byp1_EX <= !bubble && m1_ie && !ld_ie;
            byp1_DM <= !bubble && m1_ed && !m1_ie;
        end
    end
endmodule

// File: tb/tb_byp_hzd_unit.sv
// tb_byp_hzd_unit: directed and randomized checks against a stage-list reference model
module tb_byp_hzd_unit;
    localparam int AW = 4;

    logic          clk = 0, rst = 1, stall = 0, flush_ID = 0;
    logic          re0 = 0, re1 = 0, we_rf = 0, mem_rd = 0;
    logic [AW-1:0] p0_addr = 0, p1_addr = 0, dst_addr = 0;
    logic          byp0_EX, byp0_DM, byp1_EX, byp1_DM, hzd_stall;
    int            checks = 0, errors = 0;

    typedef struct {
        logic          we;
        logic          ld;
        logic [AW-1:0] dst;
    } stg_t;

    stg_t       st[3];
    logic [3:0] eflags = 0;
    wire  [3:0] flags = {byp0_EX, byp0_DM, byp1_EX, byp1_DM};

    always #5 clk = ~clk;

    byp_hzd_unit #(.ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_ID(flush_ID),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
        .dst_addr(dst_addr), .we_rf(we_rf), .mem_rd(mem_rd),
        .byp0_EX(byp0_EX), .byp0_DM(byp0_DM), .byp1_EX(byp1_EX), .byp1_DM(byp1_DM),
        .hzd_stall(hzd_stall)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // stage 0 = ID_EX, 1 = EX_DM, 2 = DM_WB
    function automatic logic mt(input logic re, input logic [AW-1:0] a, input int s);
        return re && st[s].we && a == st[s].dst && a != 0;
    endfunction

    function automatic logic ehz();
        return !flush_ID && st[0].ld && (mt(re0, p0_addr, 0) || mt(re1, p1_addr, 0));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) st[i] = '{1'b0, 1'b0, '0};
        eflags = 0;
    endtask

    task automatic cyc();
        logic bub, m0e, m0d, m1e, m1d;
        #1 check("hzd", {3'b0, hzd_stall}, {3'b0, ehz()});
        bub = flush_ID || ehz();
        m0e = mt(re0, p0_addr, 0);
        m0d = mt(re0, p0_addr, 1);
        m1e = mt(re1, p1_addr, 0);
        m1d = mt(re1, p1_addr, 1);
        @(posedge clk);
        if (!stall) begin
            eflags = bub ? 4'b0 : {m0e && !st[0].ld, m0d && !m0e, m1e && !st[0].ld, m1d && !m1e};
            st[2]  = st[1];
            st[1]  = st[0];
            st[0]  = '{we_rf && !bub, mem_rd && !bub, dst_addr};
        end
        #1 check("flags", flags, eflags);
    endtask

    task automatic set(input logic [AW-1:0] a0, input logic r0, input logic [AW-1:0] a1,
                       input logic r1, input logic [AW-1:0] d, input logic w, input logic l,
                       input logic f = 0, input logic s = 0);
        p0_addr = a0; re0 = r0; p1_addr = a1; re1 = r1;
        dst_addr = d; we_rf = w; mem_rd = l; flush_ID = f; stall = s;
    endtask

    task automatic id(input logic [AW-1:0] a0, input logic r0, input logic [AW-1:0] a1,
                      input logic r1, input logic [AW-1:0] d, input logic w, input logic l,
                      input logic f = 0, input logic s = 0);
        set(a0, r0, a1, r1, d, w, l, f, s);
        cyc();
    endtask

    initial begin
        clear_model();
        #2;
        check("rst flags", flags, 4'b0);
        check("rst hzd", {3'b0, hzd_stall}, 4'b0);
        @(negedge clk) rst = 0;

        // forward from EX
        id(0, 0, 0, 0, 3, 1, 0);
        id(3, 1, 0, 0, 9, 1, 0);
        check("t1 ex", flags, 4'b1000);

        // forward from DM on both ports
        id(0, 0, 0, 0, 3, 1, 0);
        id(0, 0, 0, 0, 0, 0, 0);
        id(3, 1, 3, 1, 4, 1, 0);
        check("t2 dm", flags, 4'b0101);

        // load-use: one stall, bubble, then DM bypass
        id(0, 0, 0, 0, 5, 1, 1);
        set(1, 0, 5, 1, 6, 1, 0);
        #1 check("t3 hz1", {3'b0, hzd_stall}, 4'b1);
        cyc();
        check("t3 bubble", flags, 4'b0);
        #1 check("t3 hz0", {3'b0, hzd_stall}, 4'b0);
        cyc();
        check("t3 dm", flags, 4'b0001);

        // r0 never matches
        id(0, 0, 0, 0, 0, 1, 1);
        id(0, 1, 0, 1, 8, 1, 0);
        check("t4 r0", flags, 4'b0);

        // EX has priority over DM
        id(0, 0, 0, 0, 7, 1, 0);
        id(0, 0, 0, 0, 7, 1, 0);
        id(7, 1, 7, 1, 1, 1, 0);
        check("t5 prio", flags, 4'b1010);

        // flush suppresses load-use stall
        id(0, 0, 0, 0, 2, 1, 1);
        set(2, 1, 0, 0, 3, 1, 0, 1);
        #1 check("t6 flush hz", {3'b0, hzd_stall}, 4'b0);
        cyc();
        check("t6 flush flags", flags, 4'b0);

        // global stall during a load-use hazard holds everything
        id(0, 0, 0, 0, 4, 1, 0);
        id(4, 1, 0, 0, 2, 1, 1);
        check("t6 pre", flags, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            id(2, 1, 0, 0, 3, 1, 0, 0, 1);
            check("t6 hold", flags, 4'b1000);
        end
        id(2, 1, 0, 0, 3, 1, 0);
        check("t6 bub", flags, 4'b0);
        id(2, 1, 0, 0, 3, 1, 0);
        check("t6 dm", flags, 4'b0100);

        // async reset mid-sequence
        id(0, 0, 0, 0, 6, 1, 0);
        id(6, 1, 6, 1, 6, 1, 1);
        rst = 1;
        #1 check("t6 rst flags", flags, 4'b0);
        check("t6 rst hzd", {3'b0, hzd_stall}, 4'b0);
        rst = 0;
        clear_model();
        id(6, 1, 6, 1, 1, 1, 0);
        check("t6 post rst", flags, 4'b0);

        // randomized traffic with occasional async reset
        for (int n = 0; n < 2000; n++) begin
            set(AW'($urandom_range(0, 3)), 1'($urandom), AW'($urandom_range(0, 3)), 1'($urandom),
                AW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 5) == 0));
            cyc();
            if ($urandom_range(0, 49) == 0) begin
                rst = 1;
                #1 check("rand rst", flags, 4'b0);
                rst = 0;
                clear_model();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
